n_adder: RTL and testbench
==========================

# n_adder

Parameterised N-bit binary adder with carry-in and carry-out, used as the integer add/subtract core of the ALU in each pipeline core. The sum and carry paths are purely combinational, so results are valid in the same cycle as the operands. A clocked output register stage captures the result for the next pipeline stage.

## Interface
Parameters:
- N, default 32, operand and sum width in bits (N >= 1).

Ports:
- clk  input  1  rising-edge clock for the output register stage.
- rst  input  1  synchronous, active-high reset; one clock, sampled on the rising edge of clk.
- en  input  1  load enable for the output register stage.
- a  input  N  operand A, unsigned or two's complement.
- b  input  N  operand B, unsigned or two's complement.
- cin  input  1  carry into bit 0.
- s  output  N  combinational sum, (a + b + cin) mod 2^N.
- cout  output  1  combinational carry out of bit N-1.
- s_q  output  N  registered s.
- cout_q  output  1  registered cout.
- ovf  output  1  combinational signed overflow. Present only with N_ADDER_OVF_EN.
- ovf_q  output  1  registered ovf. Present only with N_ADDER_OVF_EN.

## Operation
- {cout, s} = a + b + cin. The computation is exact in N+1 bits, with no truncation other than into cout.
- Carry structure:
  - 4-bit carry-lookahead groups: generate g = a&b, propagate p = a^b.
  - Group carries ripple between groups.
  - A final partial group handles N not divisible by 4.
  - The result must be bit-identical to a ripple adder for every N.
- s[i] = p[i] ^ c[i], with c[0] = cin.
- cout = c[N].
- Subtraction is performed by the caller: pass ~b and cin = 1. In that case cout = 1 means no borrow.
- ovf = c[N] ^ c[N-1]. This is 1 when a and b share a sign bit and s has the opposite sign.
- For N = 1: ovf = c[1] ^ cin.
- No X-propagation masking. X on any input may produce X on s, cout and ovf.

## Timing
- s, cout and ovf depend combinationally on a, b and cin, with zero cycle latency and no dependency on clk, rst or en. They must be valid within one combinational settle after an input change.
- Register stage, evaluated on each rising edge of clk:
  - rst = 1: s_q = 0, cout_q = 0, ovf_q = 0. Reset takes priority over en.
  - rst = 0, en = 1: s_q <= s, cout_q <= cout, ovf_q <= ovf.
  - rst = 0, en = 0: the registers hold their value.
- Registered latency is 1 cycle from the operand edge to s_q.
- Reset asserted mid-operation clears the registers only. It never affects the combinational outputs.
- Boundary cases:
  - All-ones sum with cin = 1 wraps to 0 and sets cout = 1.
  - 0 + 0 + 0 gives s = 0 and cout = 0.

## Configuration
- Macro N_ADDER_OVF_EN.
  - Defined: the ovf and ovf_q ports exist and behave as specified above.
  - Not defined: both ports are absent, and no overflow logic is built. All other ports and behaviour are unchanged.

## Test plan
- N = 32, a = 0x11111111, b = 0xEEEEEEEE, cin = 0 -> s = 0xFFFFFFFF, cout = 0, after a 1 ns settle with no clock edge.
- Same operands with cin = 1 -> s = 0x00000000, cout = 1. This covers full carry propagation across all groups.
- a = 0x7FFFFFFF, b = 0x00000001, cin = 0 -> s = 0x80000000, cout = 0, ovf = 1. Also a = 0x80000000, b = 0x80000000 -> s = 0, cout = 1, ovf = 1.
- Subtract 5 - 7: a = 5, b = ~7, cin = 1 -> s = 0xFFFFFFFE, cout = 0 (borrow).
- Register stage:
  - rst high for one edge -> s_q = 0, cout_q = 0.
  - en = 1 with a = 3, b = 4 -> s_q = 7 after the next edge.
  - en = 0 and inputs changed -> s_q holds 7.
  - rst = 1 together with en = 1 -> s_q = 0.
- Randomised sweep for N in {1, 5, 32}: at least 1000 vectors comparing {cout, s} against a + b + cin computed in N+1 bits.

Source files
------------

// File: rtl/n_adder.sv
// N-bit adder built from 4-bit carry-lookahead groups with rippled group carries,
// plus a registered copy of the result. Define N_ADDER_OVF_EN to add ovf/ovf_q.
module n_adder #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic [N-1:0] s_q,
  output logic         cout_q
`ifdef N_ADDER_OVF_EN
  ,
  output logic         ovf,
  output logic         ovf_q
`endif
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         grp_g;
  logic         grp_p;
  logic         grp_cin;

  assign g = a & b;
  assign p = a ^ b;

  // Inside a group every carry is a prefix generate/propagate over the group's
  // own carry-in; only that carry-in ripples from the previous group.
  // NOTE: loop temporaries in always_comb use blocking '=' and get a default
  // first so no latch is inferred and each bit sees the updated prefix.
  always_comb begin
    c       = '0;
    c[0]    = cin;
    grp_g   = 1'b0;
    grp_p   = 1'b1;
    grp_cin = cin;
    for (int i = 0; i < N; i++) begin
      if (i % 4 == 0) begin
        grp_g   = 1'b0;
        grp_p   = 1'b1;
        grp_cin = c[i];
      end
      grp_g    = g[i] | (p[i] & grp_g);
      grp_p    = p[i] & grp_p;
      c[i + 1] = grp_g | (grp_p & grp_cin);
    end
  end

  assign s    = p ^ c[N-1:0];
  assign cout = c[N];

  logic [N-1:0] s_d;
  logic         cout_d;

`ifdef N_ADDER_OVF_EN
  logic ovf_d;

  // For N = 1, c[N-1] is c[0], which is cin.
  assign ovf = c[N] ^ c[N-1];
`endif

  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
`ifdef N_ADDER_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (rst) begin
      s_d    = '0;
      cout_d = 1'b0;
`ifdef N_ADDER_OVF_EN
      ovf_d  = 1'b0;
`endif
    end else if (en) begin
      s_d    = s;
      cout_d = cout;
`ifdef N_ADDER_OVF_EN
      ovf_d  = ovf;
`endif
    end
  end

  // NOTE: state flops use non-blocking '<=' so every register samples its
  // d-input from before the edge; the synchronous reset lives in the d-logic.
  always_ff @(posedge clk) begin
    s_q    <= s_d;
    cout_q <= cout_d;
`ifdef N_ADDER_OVF_EN
    ovf_q  <= ovf_d;
`endif
  end

endmodule

// File: tb/tb_n_adder.sv
// Self-checking bench for n_adder: directed vectors, register stage, pipelined
// back-to-back loads and random sweeps at N = 1, 5 and 32 via a scoreboard queue.
module tb_n_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] s;
  logic        cout;
  logic [31:0] s_q;
  logic        cout_q;
  logic        ovf;
  logic        ovf_q;

  logic [4:0]  a5;
  logic [4:0]  b5;
  logic        cin5;
  logic [4:0]  s5;
  logic        cout5;
  logic [4:0]  s5_q;
  logic        cout5_q;
  logic        ovf5;
  logic        ovf5_q;

  logic [0:0]  a1;
  logic [0:0]  b1;
  logic        cin1;
  logic [0:0]  s1;
  logic        cout1;
  logic [0:0]  s1_q;
  logic        cout1_q;
  logic        ovf1;
  logic        ovf1_q;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard entries are {ovf, cout, s[31:0]}.
  logic [33:0] sb[$];
  logic [33:0] exp_v;
  logic [33:0] act_v;

`ifdef N_ADDER_OVF_EN
  localparam logic [33:0] CMP_MASK = 34'h3_FFFF_FFFF;
`else
  localparam logic [33:0] CMP_MASK = 34'h1_FFFF_FFFF;
  assign ovf    = 1'b0;
  assign ovf_q  = 1'b0;
  assign ovf5   = 1'b0;
  assign ovf5_q = 1'b0;
  assign ovf1   = 1'b0;
  assign ovf1_q = 1'b0;
`endif

  always #5 clk = ~clk;

  n_adder #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .cin(cin),
    .s(s), .cout(cout), .s_q(s_q), .cout_q(cout_q)
`ifdef N_ADDER_OVF_EN
    , .ovf(ovf), .ovf_q(ovf_q)
`endif
  );

  n_adder #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .a(a5), .b(b5), .cin(cin5),
    .s(s5), .cout(cout5), .s_q(s5_q), .cout_q(cout5_q)
`ifdef N_ADDER_OVF_EN
    , .ovf(ovf5), .ovf_q(ovf5_q)
`endif
  );

  n_adder #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .s_q(s1_q), .cout_q(cout1_q)
`ifdef N_ADDER_OVF_EN
    , .ovf(ovf1), .ovf_q(ovf1_q)
`endif
  );

  // Reference: exact (n+1)-bit sum; overflow from the operand/result sign rule.
  function automatic logic [33:0] model(input int n, input logic [31:0] x,
                                        input logic [31:0] y, input logic ci);
    logic [31:0] mask;
    logic [32:0] sum;
    logic        ov;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    x    = x & mask;
    y    = y & mask;
    sum  = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    ov   = (x[n-1] == y[n-1]) && (sum[n-1] != x[n-1]);
    return {ov, sum[n], sum[31:0] & mask};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    a   = 32'h1234_5678;
    b   = 32'h0F0F_0F0F;
    cin = 1'b1;
    sb.push_back(34'd0);
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    act_v = {ovf_q, cout_q, s_q};
    vectors++;
    if ((act_v & CMP_MASK) !== (exp_v & CMP_MASK)) begin
      miscompares++;
      $display("FAIL reset_regs: got %h expected %h", act_v, exp_v);
    end
    rst = 1'b0;
    en  = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta[7];
    logic [31:0] tb_v[7];
    logic        tc[7];
    logic [33:0] te[7];
    ta   = '{32'h1111_1111, 32'h1111_1111, 32'h7FFF_FFFF, 32'h8000_0000,
             32'd5,         32'd0,         32'hFFFF_FFFF};
    tb_v = '{32'hEEEE_EEEE, 32'hEEEE_EEEE, 32'd1,         32'h8000_0000,
             ~32'd7,        32'd0,         32'd0};
    tc   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    te   = '{{2'b00, 32'hFFFF_FFFF}, {2'b01, 32'h0000_0000},
             {2'b10, 32'h8000_0000}, {2'b11, 32'h0000_0000},
             {2'b00, 32'hFFFF_FFFE}, {2'b00, 32'h0000_0000},
             {2'b01, 32'h0000_0000}};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a   = ta[i];
      b   = tb_v[i];
      cin = tc[i];
      sb.push_back(te[i]);
      #1;
      exp_v = sb.pop_front();
      act_v = {ovf, cout, s};
      vectors++;
      if ((act_v & CMP_MASK) !== (exp_v & CMP_MASK)) begin
        miscompares++;
        $display("FAIL directed_%0d: got %h expected %h", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_register();
    @(negedge clk);
    en = 1'b1; a = 32'd3; b = 32'd4; cin = 1'b0;
    sb.push_back({2'b00, 32'd7});
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    vectors++;
    if ({cout_q, s_q} !== exp_v[32:0]) begin
      miscompares++;
      $display("FAIL reg_load: got %h expected %h", {cout_q, s_q}, exp_v[32:0]);
    end

    @(negedge clk);
    en = 1'b0; a = 32'hFFFF_FFFF; b = 32'd9; cin = 1'b1;
    sb.push_back({2'b00, 32'd7});
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    vectors++;
    if ({cout_q, s_q} !== exp_v[32:0]) begin
      miscompares++;
      $display("FAIL reg_hold: got %h expected %h", {cout_q, s_q}, exp_v[32:0]);
    end

    @(negedge clk);
    rst = 1'b1; en = 1'b1; a = 32'd1; b = 32'd2; cin = 1'b0;
    #1;
    vectors++;
    if ({cout, s} !== 33'd3) begin
      miscompares++;
      $display("FAIL comb_during_reset: got %h expected %h", {cout, s}, 33'd3);
    end
    sb.push_back(34'd0);
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    act_v = {ovf_q, cout_q, s_q};
    vectors++;
    if ((act_v & CMP_MASK) !== (exp_v & CMP_MASK)) begin
      miscompares++;
      $display("FAIL reset_over_en: got %h expected %h", act_v, exp_v);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      a   = $urandom;
      b   = (i % 3 == 0) ? ~a : $urandom;
      cin = 1'($urandom_range(0, 1));
      sb.push_back(model(32, a, b, cin));
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      act_v = {ovf_q, cout_q, s_q};
      vectors++;
      if ((act_v & CMP_MASK) !== (exp_v & CMP_MASK)) begin
        miscompares++;
        $display("FAIL b2b_%0d: got %h expected %h", i, act_v, exp_v);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_sweep();
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      a = ra; b = rb; cin = rc;
      a5 = ra[4:0]; b5 = rb[4:0]; cin5 = rc;
      a1 = ra[0:0]; b1 = rb[0:0]; cin1 = rc;
      sb.push_back(model(32, ra, rb, rc));
      sb.push_back(model(5, ra, rb, rc));
      sb.push_back(model(1, ra, rb, rc));
      #2;
      exp_v = sb.pop_front();
      act_v = {ovf, cout, s};
      vectors++;
      if ((act_v & CMP_MASK) !== (exp_v & CMP_MASK)) begin
        miscompares++;
        $display("FAIL sweep_n32_%0d: got %h expected %h", i, act_v, exp_v);
      end
      exp_v = sb.pop_front();
      act_v = {ovf5, cout5, 27'd0, s5};
      vectors++;
      if ((act_v & CMP_MASK) !== (exp_v & CMP_MASK)) begin
        miscompares++;
        $display("FAIL sweep_n5_%0d: got %h expected %h", i, act_v, exp_v);
      end
      exp_v = sb.pop_front();
      act_v = {ovf1, cout1, 31'd0, s1};
      vectors++;
      if ((act_v & CMP_MASK) !== (exp_v & CMP_MASK)) begin
        miscompares++;
        $display("FAIL sweep_n1_%0d: got %h expected %h", i, act_v, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; a = '0; b = '0; cin = 1'b0;
    a5 = '0; b5 = '0; cin5 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_register();
    test_back_to_back();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
